// File: rtl/linescanner_sensor_emulator.sv
// linescanner_sensor_emulator: cycle-accurate line-scan sensor model driven by array strobes.
// Define LINESCAN_EMU_RAMP_EN for a deterministic (index + line) ramp instead of flat exposure data.
module linescanner_sensor_emulator #(
  parameter int PIXELS_PER_LINE = 128,
  parameter int ADC_CYCLES = 16
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       rst_cvc,
  input  logic       rst_cds,
  input  logic       sample,
  input  logic       load_pulse,
  output logic       end_adc,
  output logic       lval,
  output logic [7:0] data,
  output logic       protocol_error
);
  localparam int IW = $clog2(PIXELS_PER_LINE);
  typedef enum logic {CONV_IDLE, CONV_BUSY} conv_t;
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_t;
  conv_t conv_state, conv_next;
  rd_t rd_state, rd_next;
  logic sample_q, load_q, cvc_q, armed, hold_valid;
  logic [15:0] exp_cnt, conv_val, hold_val, out_val, out_next;
  logic [7:0] adc_cnt, line_cnt, line_next, pix_next, data_next;
  logic [IW-1:0] idx, idx_next;
  logic sample_rise, sample_fall, load_rise, abort, conv_start, conv_done, load_ok, line_end, err;
  always_comb begin
    sample_rise = sample & ~sample_q;
    sample_fall = ~sample & sample_q;
    load_rise = load_pulse & ~load_q;
    abort = rst_cvc & ~cvc_q & armed;
    conv_start = sample_fall & armed & ~abort & (conv_state == CONV_IDLE);
    conv_done = (conv_state == CONV_BUSY) && (adc_cnt == 8'd0);
    load_ok = load_rise & (rd_state == RD_IDLE) & hold_valid;
    line_end = (rd_state == RD_ACTIVE) && (idx == IW'(PIXELS_PER_LINE - 1));
    conv_next = conv_start ? CONV_BUSY : conv_done ? CONV_IDLE : conv_state;
    rd_next = load_ok ? RD_ACTIVE : line_end ? RD_IDLE : rd_state;
    idx_next = (load_ok || line_end) ? '0 : (rd_state == RD_ACTIVE) ? idx + 1'b1 : idx;
    out_next = load_ok ? hold_val : out_val;
    line_next = line_end ? line_cnt + 8'd1 : line_cnt;
    // A load that coincides with the last pixel still counts as mid-readout, hence ~load_ok alone.
    err = (sample_rise & (rst_cvc | rst_cds)) | abort
        | (sample_fall & armed & ~abort & (conv_state == CONV_BUSY))
        | (conv_done & hold_valid) | (load_rise & ~load_ok);
`ifdef LINESCAN_EMU_RAMP_EN
    pix_next = 8'(idx_next) + line_next;
`else
    pix_next = (|out_next[15:8]) ? 8'hFF : out_next[7:0];
`endif
    data_next = (rd_next == RD_ACTIVE) ? pix_next : 8'd0;
  end
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      sample_q <= 1'b0;
      load_q <= 1'b0;
      cvc_q <= 1'b0;
      conv_state <= CONV_IDLE;
      rd_state <= RD_IDLE;
      armed <= 1'b0;
      hold_valid <= 1'b0;
      exp_cnt <= '0;
      conv_val <= '0;
      hold_val <= '0;
      out_val <= '0;
      adc_cnt <= '0;
      line_cnt <= '0;
      idx <= '0;
      data <= '0;
      protocol_error <= 1'b0;
    end else begin
      sample_q <= sample;
      load_q <= load_pulse;
      cvc_q <= rst_cvc;
      conv_state <= conv_next;
      rd_state <= rd_next;
      idx <= idx_next;
      out_val <= out_next;
      line_cnt <= line_next;
      data <= data_next;
      protocol_error <= protocol_error | err;
      if (sample_rise && !rst_cvc && !rst_cds) begin
        armed <= 1'b1;
        exp_cnt <= 16'd1;
      end else if (abort || sample_fall) armed <= 1'b0;
      else if (armed && sample && exp_cnt != 16'hFFFF) exp_cnt <= exp_cnt + 16'd1;
      if (conv_start) begin
        conv_val <= exp_cnt;
        adc_cnt <= 8'(ADC_CYCLES - 1);
      end else if (conv_state == CONV_BUSY && adc_cnt != 8'd0) adc_cnt <= adc_cnt - 8'd1;
      if (conv_done) begin
        hold_val <= conv_val;
        hold_valid <= 1'b1;
      end else if (load_ok) hold_valid <= 1'b0;
    end
  end
  assign end_adc = (conv_state == CONV_IDLE);
  assign lval = (rd_state == RD_ACTIVE);
endmodule
